// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and default sizing for the scoreboard register
//               file. Holds the clear-sequencer state encoding and the default
//               width, depth and read-port count used by the top level.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Clear sequencer states. IDLE is the only state in which the block
    // accepts writes and reserves.
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } clear_state_t;

    localparam int c_default_width = 32;
    localparam int c_default_depth = 32;
    localparam int c_default_nread = 2;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_entry.sv
`default_nettype none
// ============================================================================
// Module      : regfile_entry
// Description : One register of the scoreboard file: a WIDTH-bit data word
//               plus a busy (pending-write) flag.
// Ports       : clk, reset_n      - clock, async active-low reset
//               i_write           - store i_write_data, clear busy
//               i_write_data      - value to store
//               i_reserve         - set busy (wins over a same-cycle write)
//               i_clear           - zero data and busy (wins over all)
//               o_data, o_busy    - current contents
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_entry #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_write,
    input  logic [WIDTH-1:0] i_write_data,
    input  logic             i_reserve,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_data,
    output logic             o_busy
);

    logic [WIDTH-1:0] r_data;
    logic             r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
            r_busy <= 1'b0;
        end else if (i_clear) begin
            r_data <= '0;
            r_busy <= 1'b0;
        end else begin
            if (i_write) begin
                r_data <= i_write_data;
            end
            // A reserve issued alongside the writeback re-marks the entry,
            // so the busy flag ends set.
            if (i_reserve) begin
                r_busy <= 1'b1;
            end else if (i_write) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_data = r_data;
    assign o_busy = r_busy;

endmodule : regfile_entry
`default_nettype wire

// File: rtl/scoreboard_regfile.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_regfile
// Description : Register file with per-register busy (scoreboard) bits,
//               NREAD combinational read ports with write-first bypass, one
//               writeback port, one reserve port and a sequential clear.
// Ports       : clk, reset_n            - clock, async active-low reset
//               clear_req               - start a DEPTH-cycle clear
//               ready                   - idle, accepting writes/reserves
//               read_address/read_data  - NREAD packed read ports
//               read_busy               - per-port pending-write flag
//               write_enable/address/data - writeback port
//               reserve_enable/address  - reserve request
//               reserve_accept          - reserve taken this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_regfile
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = c_default_width,
    parameter  int DEPTH    = c_default_depth,
    parameter  int NREAD    = c_default_nread,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear_req,
    output logic                    ready,
    input  logic [NREAD*ADDR_W-1:0] read_address,
    output logic [NREAD*WIDTH-1:0]  read_data,
    output logic [NREAD-1:0]        read_busy,
    input  logic                    write_enable,
    input  logic [ADDR_W-1:0]       write_address,
    input  logic [WIDTH-1:0]        write_data,
    input  logic                    reserve_enable,
    input  logic [ADDR_W-1:0]       reserve_address,
    output logic                    reserve_accept
);

    localparam logic [ADDR_W:0]   c_depth_ext  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last_index = ADDR_W'(DEPTH - 1);

    clear_state_t      r_state;
    logic [ADDR_W-1:0] r_index;

    logic [WIDTH-1:0]  w_entry_data [DEPTH];
    logic              w_entry_busy [DEPTH];

    logic              w_clearing;
    logic              w_wr_accept;
    logic              w_rsv_in_range;
    logic              w_rsv_busy;
    logic              w_rsv_set;

    // True for addresses that map to real storage (in range and not the
    // hardwired zero register).
    function automatic logic addr_is_live(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < c_depth_ext) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign ready      = (r_state == IDLE);
    assign w_clearing = (r_state == CLEARING);

    // A clear request wins over a same-cycle write: the write is dropped and
    // therefore neither bypasses nor commits.
    assign w_wr_accept = write_enable && ready && !clear_req && addr_is_live(write_address);

    assign w_rsv_in_range = ({1'b0, reserve_address} < c_depth_ext);
    assign w_rsv_busy     = w_rsv_in_range ? w_entry_busy[reserve_address] : 1'b0;

    assign reserve_accept = ready && reserve_enable && w_rsv_in_range &&
                            (!w_rsv_busy || (w_wr_accept && (write_address == reserve_address)));

    // The zero register may accept a reserve but never records it.
    assign w_rsv_set = reserve_accept && addr_is_live(reserve_address);

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_index <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clear_req) begin
                        r_state <= CLEARING;
                        r_index <= '0;
                    end
                end
                CLEARING: begin
                    if (r_index == c_last_index) begin
                        r_state <= IDLE;
                        r_index <= '0;
                    end else begin
                        r_index <= r_index + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_index <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    for (genvar j = 0; j < DEPTH; j++) begin : g_entry
        logic w_write;
        logic w_reserve;
        logic w_clear;

        assign w_write   = w_wr_accept && (write_address == ADDR_W'(j));
        assign w_reserve = w_rsv_set && (reserve_address == ADDR_W'(j));
        assign w_clear   = w_clearing && (r_index == ADDR_W'(j));

        regfile_entry #(
            .WIDTH (WIDTH)
        ) u_entry (
            .clk          (clk),
            .reset_n      (reset_n),
            .i_write      (w_write),
            .i_write_data (write_data),
            .i_reserve    (w_reserve),
            .i_clear      (w_clear),
            .o_data       (w_entry_data[j]),
            .o_busy       (w_entry_busy[j])
        );
    end

    // ------------------------------------------------------------------
    // Read ports: write-first bypass; an accepted write also hides the
    // busy bit it is about to clear.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [ADDR_W-1:0] w_addr;
        logic              w_live;
        logic              w_hit;

        assign w_addr = read_address[i*ADDR_W +: ADDR_W];
        assign w_live = addr_is_live(w_addr);
        assign w_hit  = w_wr_accept && (write_address == w_addr);

        assign read_data[i*WIDTH +: WIDTH] = !w_live ? '0 :
                                             w_hit   ? write_data :
                                                       w_entry_data[w_addr];
        assign read_busy[i] = w_live && !w_hit && w_entry_busy[w_addr];
    end

endmodule : scoreboard_regfile
`default_nettype wire

// File: tb/tb_scoreboard_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_scoreboard_regfile
// Description : Self-checking bench for scoreboard_regfile: directed scenarios
//               with literal expectations plus randomized traffic compared
//               every cycle against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scoreboard_regfile;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   clear_req;
    logic                   ready;
    logic [NREAD*AW-1:0]    read_address;
    logic [NREAD*WIDTH-1:0] read_data;
    logic [NREAD-1:0]       read_busy;
    logic                   write_enable;
    logic [AW-1:0]          write_address;
    logic [WIDTH-1:0]       write_data;
    logic                   reserve_enable;
    logic [AW-1:0]          reserve_address;
    logic                   reserve_accept;

    always #5 clk = ~clk;

    scoreboard_regfile #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NREAD    (NREAD),
        .ZERO_REG (1)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .clear_req       (clear_req),
        .ready           (ready),
        .read_address    (read_address),
        .read_data       (read_data),
        .read_busy       (read_busy),
        .write_enable    (write_enable),
        .write_address   (write_address),
        .write_data      (write_data),
        .reserve_enable  (reserve_enable),
        .reserve_address (reserve_address),
        .reserve_accept  (reserve_accept)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: plain arrays plus a count of clear cycles left.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] m_data [DEPTH];
    bit               m_busy [DEPTH];
    int               m_clr_left;
    bit               m_wa;
    bit               m_ra;

    function automatic bit m_wacc();
        return write_enable && (m_clr_left == 0) && !clear_req && (write_address != 0);
    endfunction

    function automatic bit m_racc();
        return (m_clr_left == 0) && reserve_enable &&
               (!m_busy[reserve_address] || (m_wacc() && (write_address == reserve_address)));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_data[k] = '0;
                m_busy[k] = 1'b0;
            end
            m_clr_left = 0;
        end else if (m_clr_left > 0) begin
            m_data[DEPTH - m_clr_left] = '0;
            m_busy[DEPTH - m_clr_left] = 1'b0;
            m_clr_left = m_clr_left - 1;
        end else begin
            m_wa = m_wacc();
            m_ra = m_racc();
            if (m_wa) begin
                m_data[write_address] = write_data;
                m_busy[write_address] = 1'b0;
            end
            if (m_ra && reserve_address != 0) m_busy[reserve_address] = 1'b1;
            if (clear_req) m_clr_left = DEPTH;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            logic [AW-1:0]    a;
            logic [WIDTH-1:0] ed;
            logic             eb;
            check("ready", ready, m_clr_left == 0);
            check("reserve_accept", reserve_accept, m_racc());
            for (int i = 0; i < NREAD; i++) begin
                a = read_address[i*AW +: AW];
                if (a == 0) begin
                    ed = '0;
                    eb = 1'b0;
                end else if (m_wacc() && write_address == a) begin
                    ed = write_data;
                    eb = 1'b0;
                end else begin
                    ed = m_data[a];
                    eb = m_busy[a];
                end
                check($sformatf("read_data[%0d] addr %0d", i, a), read_data[i*WIDTH +: WIDTH], ed);
                check($sformatf("read_busy[%0d] addr %0d", i, a), read_busy[i], eb);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle_inputs();
        clear_req       = 1'b0;
        write_enable    = 1'b0;
        write_address   = '0;
        write_data      = '0;
        reserve_enable  = 1'b0;
        reserve_address = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input int p, input int a);
        read_address[p*AW +: AW] = AW'(a);
    endtask

    task automatic do_write(input int a, input logic [WIDTH-1:0] d);
        write_enable  = 1'b1;
        write_address = AW'(a);
        write_data    = d;
    endtask

    task automatic do_reserve(input int a);
        reserve_enable  = 1'b1;
        reserve_address = AW'(a);
    endtask

    function automatic logic [WIDTH-1:0] rd(input int p);
        return read_data[p*WIDTH +: WIDTH];
    endfunction

    // Sweep every address through both ports and require zero data/busy.
    task automatic expect_all_zero(input string tag);
        for (int a = 0; a < DEPTH; a += 2) begin
            set_ra(0, a);
            set_ra(1, a + 1);
            #2;
            check({tag, " data p0"}, rd(0), 0);
            check({tag, " data p1"}, rd(1), 0);
            check({tag, " busy"}, read_busy, 0);
            next();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int cnt;

    initial begin
        idle_inputs();
        read_address = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        set_ra(0, 5);
        set_ra(1, 31);
        #1;
        check("reset ready", ready, 1);
        check("reset reserve_accept", reserve_accept, 0);
        check("reset read_data", read_data, 0);
        check("reset read_busy", read_busy, 0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Plain write then read next cycle
        next(); do_write(5, 32'h1234_5678); set_ra(0, 5);
        next(); idle_inputs(); #2;
        check("x5 read", rd(0), 32'h1234_5678);
        check("x5 busy", read_busy[0], 0);

        // Same-cycle bypass and the zero register
        next(); do_write(7, 32'hDEAD_BEEF); set_ra(1, 7); #2;
        check("x7 bypass", rd(1), 32'hDEAD_BEEF);
        next(); do_write(0, 32'hFFFF_FFFF); set_ra(0, 0); #2;
        check("x0 bypass blocked", rd(0), 0);
        next(); idle_inputs(); #2;
        check("x0 after write", rd(0), 0);

        // Reserve / double reserve / writeback
        next(); do_reserve(9); #2;
        check("rsv x9 accept", reserve_accept, 1);
        next(); set_ra(0, 9); #2;
        check("x9 busy", read_busy[0], 1);
        check("rsv x9 again", reserve_accept, 0);
        next(); idle_inputs(); do_write(9, 32'h42); #2;
        check("x9 busy forced low", read_busy[0], 0);
        next(); idle_inputs(); #2;
        check("x9 data", rd(0), 32'h42);
        check("x9 busy after wb", read_busy[0], 0);

        // Busy register: simultaneous writeback and re-reserve
        next(); do_reserve(3); #2;
        check("rsv x3 accept", reserve_accept, 1);
        next(); do_reserve(3); do_write(3, 32'h11); set_ra(1, 3); #2;
        check("rsv x3 with wb", reserve_accept, 1);
        next(); idle_inputs(); #2;
        check("x3 data", rd(1), 32'h11);
        check("x3 busy", read_busy[1], 1);

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 600; n++) begin
            next();
            write_enable    = ($urandom % 2) == 0;
            write_address   = AW'(($urandom % 2) ? $urandom % 8 : $urandom % DEPTH);
            write_data      = $urandom;
            reserve_enable  = ($urandom % 3) == 0;
            reserve_address = AW'(($urandom % 2) ? $urandom % 8 : $urandom % DEPTH);
            clear_req       = ($urandom % 97) == 0;
            for (int p = 0; p < NREAD; p++) begin
                if ($urandom % 4 == 0) set_ra(p, int'(write_address));
                else                   set_ra(p, $urandom % DEPTH);
            end
        end
        next(); idle_inputs();
        cnt = 0;
        while (!ready && cnt < 40) begin
            next();
            cnt++;
        end
        check("ready after random", ready, 1);

        // Fill, clear with a discarded write in the request cycle, count
        // ready-low cycles while hammering writes.
        for (int a = 1; a < DEPTH; a++) begin
            next(); do_write(a, 32'h100 + a);
        end
        next(); idle_inputs(); clear_req = 1'b1; do_write(4, 32'hAAAA);
        next(); clear_req = 1'b0;
        cnt = 0;
        for (int b = 0; b < 100; b++) begin
            do_write($urandom % DEPTH, $urandom | 1);
            #2;
            if (ready) begin
                write_enable = 1'b0;
                break;
            end
            cnt++;
            next();
        end
        check("clear ready-low cycles", cnt, 32);
        idle_inputs();
        next();
        expect_all_zero("after clear");

        // Reset in the middle of a clear
        do_reserve(20); do_write(25, 32'h5555);
        next(); idle_inputs(); clear_req = 1'b1;
        next(); clear_req = 1'b0;
        repeat (9) next();
        #1;
        set_ra(0, 20);
        set_ra(1, 25);
        #1;
        check("pre-reset x25", rd(1), 32'h5555);
        check("pre-reset x20 busy", read_busy[0], 1);
        check("pre-reset ready", ready, 0);
        reset_n = 1'b0;
        #1;
        check("mid-clear reset ready", ready, 1);
        check("mid-clear reset data", read_data, 0);
        check("mid-clear reset busy", read_busy, 0);
        next();
        reset_n = 1'b1;
        #1;
        check("after reset release ready", ready, 1);
        next();
        expect_all_zero("after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_scoreboard_regfile
`default_nettype wire
